// File: rtl/rot_pkg.sv
// Shared types and constants for the sequential rotate engine.
// Pulled into the other files with a module-header import.
package rot_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/rot_step.sv
// Purely combinational rotator that moves a word by one bit position,
// to the right or to the left.
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dir,
  output logic [WIDTH-1:0] b
);

  // Single-position rotate selected by dir
  always_comb begin
    b = a;
    case (dir)
      DIR_R:   b = {a[0], a[WIDTH-1:1]};
      DIR_L:   b = {a[WIDTH-2:0], a[WIDTH-1]};
      default: b = a;
    endcase
  end

endmodule

// File: rtl/rot_seq_unit.sv
// Sequential rotate engine: accepts a word and an amount, rotates it one
// position per clock, then holds the result on a valid/ready output.
module rot_seq_unit
  import rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [CNT_W:0]   WIDTH_X  = (CNT_W + 1)'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dir_r;
  logic [WIDTH-1:0] step_s;
  logic [CNT_W:0]   amt_ext_s;
  logic [CNT_W-1:0] amt_mod_s;

  rot_step #(.WIDTH(WIDTH)) u_step (
    .a   (data_r),
    .dir (dir_r),
    .b   (step_s)
  );

  // Fold in_amt into 0..WIDTH-1; one subtract suffices since 2^CNT_W < 2*WIDTH
  always_comb begin
    amt_ext_s = {1'b0, in_amt};
    if (amt_ext_s >= WIDTH_X) begin
      amt_mod_s = CNT_W'(amt_ext_s - WIDTH_X);
    end else begin
      amt_mod_s = in_amt;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = (amt_mod_s != CNT_ZERO) ? ST_ROT : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ROT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ROT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on accept, one rotation per clock while rotating
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_r <= {WIDTH{1'b0}};
      cnt_r  <= CNT_ZERO;
      dir_r  <= DIR_R;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            dir_r  <= in_dir;
            cnt_r  <= amt_mod_s;
          end
        end
        ST_ROT: begin
          data_r <= step_s;
          cnt_r  <= cnt_r - CNT_ONE;
        end
        default: begin
          data_r <= data_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_ROT);
  assign out_valid = (state_r == ST_DONE);
  assign out_data  = data_r;

endmodule

// File: tb/tb_rot_seq_unit.sv
// Self-checking bench for rot_seq_unit: directed vector table, backpressure
// and asynchronous-reset sequences, then an exhaustive randomized sweep.
module tb_rot_seq_unit;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [5:0] exp_data;
    int         exp_busy;
  } vec_t;

  vec_t       vecs[7];
  logic [5:0] exp_q[$];
  int         accepted = 0;
  int         got_n    = 0;
  logic [5:0] res;
  int         lat;
  int         bcnt;
  int         hold_ok;
  int         vcnt;

  rot_seq_unit #(.WIDTH(6), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: rotate right by k is a window into the doubled word; left by k is right by WIDTH-k
  function automatic logic [5:0] ref_rot(input logic [5:0] d, input int amt, input logic left);
    int          k;
    logic [11:0] dd;
    k = amt % 6;
    if (left) k = (6 - k) % 6;
    dd = {d, d} >> k;
    return dd[5:0];
  endfunction

  task automatic do_op(input logic [5:0] d, input logic [2:0] a, input logic dr,
                       output logic [5:0] r, output int l, output int bc);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_amt = a + 3'd3; in_dir = ~dr;
    l = 0; bc = 0; r = 6'd0;
    forever begin
      @(negedge clk);
      if (busy) bc++;
      if (out_valid) begin
        r = out_data;
        break;
      end
      l++;
      if (l > 40) begin
        check("op_timeout", 32'(l), 32'd0);
        break;
      end
    end
  endtask

  task automatic sweep_drive();
    int guard;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      while ($urandom_range(3, 0) == 0) @(negedge clk);
      in_valid = 1'b1; in_data = 6'(i); in_amt = 3'(i >> 6); in_dir = 1'(i >> 9);
      guard = 0;
      while (!in_ready && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("sweep_accept_timeout", 32'(guard), 32'd0);
        break;
      end
      exp_q.push_back(ref_rot(6'(i), (i >> 6) & 7, 1'(i >> 9)));
      accepted++;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic sweep_monitor();
    int         cyc = 0;
    logic [5:0] e;
    while (got_n < 1024 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(1, 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sweep_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sweep_data", 32'(out_data), 32'(e));
        end
        got_n++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{6'b000001, 3'd1, 1'b0, 6'b100000, 1};
    vecs[1] = '{6'b101100, 3'd2, 1'b0, 6'b001011, 2};
    vecs[2] = '{6'b000001, 3'd2, 1'b1, 6'b000100, 2};
    vecs[3] = '{6'b110101, 3'd0, 1'b0, 6'b110101, 0};
    vecs[4] = '{6'b000010, 3'd7, 1'b0, 6'b000001, 1};
    vecs[5] = '{6'b100000, 3'd6, 1'b1, 6'b100000, 0};
    vecs[6] = '{6'b000011, 3'd5, 1'b1, 6'b100001, 5};

    rst_b = 1'b0; in_valid = 1'b0; in_data = 6'd0; in_amt = 3'd0; in_dir = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].data, vecs[i].amt, vecs[i].dir, res, lat, bcnt);
      check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_busy));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), {30'd0, in_ready, out_valid}, 32'd2);
    end

    // Backpressure: result held while out_ready is low, no accept on release edge
    out_ready = 1'b0;
    do_op(6'b101010, 3'd3, 1'b0, res, lat, bcnt);
    check("bp_data", 32'(res), 32'(6'b010101));
    in_valid = 1'b1; in_data = 6'b111111; in_amt = 3'd1; in_dir = 1'b1;
    hold_ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== 6'b010101 || in_ready) hold_ok = 0;
    end
    check("bp_hold", 32'(hold_ok), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
    in_valid = 1'b0;

    // Asynchronous reset after two of five rotations
    @(negedge clk);
    in_valid = 1'b1; in_data = 6'b000111; in_amt = 3'd5; in_dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_b = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("mid_rst_no_emit", 32'(vcnt), 32'd0);
    do_op(6'b000111, 3'd2, 1'b1, res, lat, bcnt);
    check("post_rst_data", 32'(res), 32'(6'b011100));
    check("post_rst_latency", 32'(lat), 32'd2);

    // Exhaustive sweep with random backpressure and input gaps
    @(negedge clk);
    fork
      sweep_drive();
      sweep_monitor();
    join
    out_ready = 1'b1;
    check("sweep_results", 32'(got_n), 32'(accepted));
    check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sweep_accepted", 32'(accepted), 32'd1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_seq_unit.md
Name: rot_seq_unit

Overview:
- Sequential rotate engine wrapped around a one-position rotator step.
- Captures a word and a rotate amount over a valid/ready input handshake.
- Rotates the word by one position per clock, right or left, until the amount is used up.
- Presents the result on a valid/ready output handshake to the downstream consumer.

Parameters:
- WIDTH, 6, data word width in bits.
- CNT_W, 3, width of the rotate-amount field and of the internal counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an operand.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  CNT_W  rotate amount in positions.
- in_dir  input  1  0 = rotate right, 1 = rotate left.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  rotated word.
- busy  output  1  high in ROT state.

Behaviour:
- Reset (rst_b low, asynchronous, takes effect immediately):
  - state = IDLE.
  - data_q = 0, cnt_q = 0, dir_q = 0.
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1 (IDLE value).
  - Reset asserted in any state, including mid-rotation or while out_valid is high, discards the operation; nothing is emitted afterwards.
- States: IDLE, ROT, DONE, 2-bit encoding.
- IDLE:
  - in_ready = 1.
  - Accept happens on the rising edge where in_valid && in_ready.
  - On accept: data_q <= in_data, dir_q <= in_dir, cnt_q <= in_amt mod WIDTH.
  - Next state is ROT if (in_amt mod WIDTH) != 0, otherwise DONE.
  - in_amt >= WIDTH is reduced modulo WIDTH (WIDTH=6: 6->0, 7->1).
- ROT:
  - Each clock: data_q <= one-position rotate of data_q in direction dir_q; cnt_q <= cnt_q - 1.
  - When cnt_q == 1, that clock's rotation is the last one and next state is DONE.
  - in_ready = 0 and busy = 1.
  - in_valid is ignored.
- DONE:
  - out_valid = 1, out_data = data_q, in_ready = 0.
  - data_q is held stable for as long as out_ready is low.
  - On the edge where out_valid && out_ready, go to IDLE.
  - No new operand is accepted on that same edge; the earliest next accept is the following edge.
- Rotate definitions:
  - Right by one: {d[0], d[WIDTH-1:1]}.
  - Left by one: {d[WIDTH-2:0], d[WIDTH-1]}.
- Latency: with accept at edge E0 and k = in_amt mod WIDTH, out_valid rises after edge E0+k.
  - k = 0 means out_valid is high in the cycle right after E0.
- Throughput: one operation per k+2 cycles when out_ready is held high.
- out_data is registered; no combinational path from in_* to out_*.
- in_data, in_amt and in_dir are sampled only on the accept edge; changes at any other time have no effect.

Decomposition:
- Package rot_pkg holds:
  - state enumeration ST_IDLE = 2'd0, ST_ROT = 2'd1, ST_DONE = 2'd2;
  - DIR_R = 1'b0, DIR_L = 1'b1;
  - default WIDTH = 6 and CNT_W = 3.
- Sub-module rot_step:
  - purely combinational one-position rotator;
  - ports: a[WIDTH-1:0], dir, b[WIDTH-1:0];
  - instantiated once in the datapath feeding data_q.
- Modulo reduction of in_amt is done inline with one compare-and-subtract, valid because 2^CNT_W < 2*WIDTH.

Test Plan:
- Right by 1: in_data=6'b000001, in_amt=1, in_dir=0 -> out_data=6'b100000; out_valid high in the cycle after edge E0+1; busy high for exactly 1 cycle.
- Right by 2 and left by 2:
  - in_data=6'b101100, amt=2, dir=0 -> 6'b001011;
  - in_data=6'b000001, amt=2, dir=1 -> 6'b000100;
  - busy high 2 cycles in each case.
- Zero and modulo amounts:
  - amt=0, data=6'b110101 -> 6'b110101, out_valid in the cycle after E0, busy never high;
  - amt=7, data=6'b000010, dir=0 -> 6'b000001 after 1 rotation.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready stays 0; pulse out_ready -> IDLE and in_ready=1 on the next cycle.
- Mid-operation reset: amt=5; drop rst_b asynchronously (between clock edges) after 2 rotations -> immediately state=IDLE, out_valid=0, data_q=0, busy=0; after release, a fresh operand is processed normally.
- Exhaustive sweep: all 64 in_data values × amt 0..7 × both directions with random out_ready -> every out_data matches the reference rotate model, and exactly one result per accepted operand.
